// File: rtl/serial_ripple_adder_if.sv
// Operand/result bundle for the bit-serial adder: requester drives the
// operands and start, the adder returns status and the registered result.
interface serial_ripple_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_ripple_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder evaluation per clock, LSB first,
// with the running carry held in a flop. Result is published only on RUN->DONE.
module serial_ripple_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_ripple_adder_if.slave bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic accept;
    logic last_bit;
    logic fa_sum;
    logic fa_carry;
    logic busy;
    logic done;

    // A start is taken whenever the adder is not mid-addition.
    assign accept   = bus.start && (state_q != StRun);
    assign last_bit = (state_q == StRun) && (cnt_q == CntLast);

    // Single full-adder cell fed from the operand shift registers' LSBs.
    assign fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_carry = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = accept ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StRun:   busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: operand load, per-bit shift, and result publish.
    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            a_sr_d  = bus.a;
            b_sr_d  = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            res_d   = {fa_sum, res_q[WIDTH-1:1]};
            carry_d = fa_carry;
            if (last_bit) begin
                // Counter parks at the last index; sum/cout change only here.
                sum_d  = {fa_sum, res_q[WIDTH-1:1]};
                cout_d = fa_carry;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Scoreboard bench for serial_ripple_adder: accepted starts push a+b+cin,
// each done pops and compares; sum/cout hold and busy length are tracked.
module tb_serial_ripple_adder;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;

    serial_ripple_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_ripple_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] last_res;
    int unsigned    busy_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    // Monitor: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (rst) begin
            exp_q.delete();
            last_res = '0;
            busy_cnt = 0;
        end else begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("result", {bus.cout, bus.sum}, e);
                    last_res = e;
                end
                check_eq("busy_len", busy_cnt, WIDTH);
                busy_cnt = 0;
            end else begin
                check_eq("hold", {bus.cout, bus.sum}, last_res);
            end
            if (bus.busy) busy_cnt++;
            if (bus.start && !bus.busy) exp_q.push_back(model(bus.a, bus.b, bus.cin));
        end
    end

    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is high, or flags a timeout.
    task automatic wait_done();
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 4 * WIDTH);
        if (!bus.done) check_eq("done_timeout", 0, 1);
    endtask

    initial begin
        int unsigned gap;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_sum", bus.sum, 0);
        check_eq("rst_cout", bus.cout, 0);
        rst = 1'b0;

        // Directed operand patterns.
        drive_start(8'hFF, 8'h01, 1'b0);
        wait_done();
        drive_start(8'h5A, 8'hA5, 1'b1);
        wait_done();
        drive_start(8'h3C, 8'h0F, 1'b0);
        wait_done();
        repeat (3) @(posedge clk);

        // Start pulses during RUN must be ignored.
        drive_start(8'h12, 8'h34, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.a = 8'hEE; bus.b = 8'hDD; bus.cin = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'h77; bus.b = 8'h99; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();

        // Asynchronous reset in the 4th RUN cycle aborts with no done.
        drive_start(8'hC3, 8'h3C, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_done", bus.done, 0);
        check_eq("abort_sum", bus.sum, 0);
        check_eq("abort_cout", bus.cout, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2 * WIDTH) @(posedge clk);
        drive_start(8'h80, 8'h80, 1'b1);
        wait_done();

        // start held high: back-to-back results every WIDTH+1 cycles.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'h81; bus.b = 8'h7E; bus.cin = 1'b1;
        wait_done();
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
                if (gap == 1) check_eq("b2b_rerun", bus.busy, 1);
            end while (!bus.done && gap < 4 * WIDTH);
            check_eq("b2b_period", gap, WIDTH + 1);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();
        repeat (2) @(posedge clk);

        // Random operands with random idle gaps.
        for (int i = 0; i < 1000; i++) begin
            drive_start(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
